// File: rtl/riscv_core_pkg.sv
// Shared types and constants for the RISC-V core front end.
package riscv_core_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: capture, hold (default) or flush to a NOP bubble.
import riscv_core_pkg::*;

module if_id_register (
    input  logic            clk,
    input  logic            reset,
    input  logic            capture_i,
    input  logic            flush_i,
    input  logic [ILEN-1:0] inst_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [ILEN-1:0] if_instruction_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic            if_valid_o
);

    logic [ILEN-1:0] inst_q;
    logic [XLEN-1:0] pc_q;
    logic            valid_q;

    // Flush leaves the PC field untouched; it is meaningless while valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_q  <= NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            inst_q  <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (capture_i) begin
            inst_q  <= inst_i;
            pc_q    <= pc_i;
            valid_q <= 1'b1;
        end
    end

    assign if_instruction_o = inst_q;
    assign if_pc_o          = pc_q;
    assign if_valid_o       = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory address, and feeds IF/ID.
// Handles stall, redirect with wrong-path flush, and halting on bad fetches.
import riscv_core_pkg::*;

module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          IMEM_BYTES = 152
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_target,
    output logic [63:0] inst_address,
    input  logic [31:0] instruction,
    output logic [31:0] if_instruction,
    output logic [63:0] if_pc,
    output logic        if_valid,
    output logic        halted,
    output logic        misaligned_fault,
    output logic [31:0] fetch_count
);

    // Subtracting on the constant side keeps pc+3 from wrapping into the compare.
    localparam logic [XLEN-1:0] PC_LIMIT = 64'(IMEM_BYTES) - 64'd3;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;
    logic [31:0]     count_q, count_d;
    logic            capture;
    logic            flush;
    logic            target_aligned;

    assign target_aligned = (redirect_target[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        count_d = count_q;
        capture = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (target_aligned) begin
                        pc_d = redirect_target;
                    end else begin
                        state_d = HALT;
                        fault_d = 1'b1;
                    end
                end else if (!stall) begin
                    if (pc_q >= PC_LIMIT) begin
                        state_d = HALT;
                        flush   = 1'b1;
                    end else begin
                        capture = 1'b1;
                        pc_d    = pc_q + 64'd4;
                        count_d = count_q + 32'd1;
                    end
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    if (target_aligned) begin
                        pc_d    = redirect_target;
                        fault_d = 1'b0;
                        state_d = RUN;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    if_id_register u_if_id (
        .clk              (clk),
        .reset            (reset),
        .capture_i        (capture),
        .flush_i          (flush),
        .inst_i           (instruction),
        .pc_i             (pc_q),
        .if_instruction_o (if_instruction),
        .if_pc_o          (if_pc),
        .if_valid_o       (if_valid)
    );

    assign inst_address     = pc_q;
    assign halted           = (state_q == HALT);
    assign misaligned_fault = fault_q;
    assign fetch_count      = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a capture scoreboard and a small reference model.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_target = 64'h0;
    logic [63:0] inst_address;
    logic [31:0] instruction;
    logic [31:0] if_instruction;
    logic [63:0] if_pc;
    logic        if_valid;
    logic        halted;
    logic        misaligned_fault;
    logic [31:0] fetch_count;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } cap_t;

    cap_t sb[$];
    cap_t last_cap;

    logic [31:0] mem [0:37];

    // Reference model state: 0 = boot, 1 = run, 2 = halt
    int          m_state = 0;
    logic [63:0] m_pc    = 64'h0;
    logic        m_valid = 1'b0;
    logic        m_fault = 1'b0;
    logic [31:0] m_cnt   = 32'h0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [63:0] a);
        if (a < 64'd152) return mem[int'(a >> 2)];
        return 32'h0;
    endfunction

    assign instruction = memword(inst_address);

    instruction_fetch_unit #(
        .RESET_PC   (64'h0),
        .IMEM_BYTES (152)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .inst_address     (inst_address),
        .instruction      (instruction),
        .if_instruction   (if_instruction),
        .if_pc            (if_pc),
        .if_valid         (if_valid),
        .halted           (halted),
        .misaligned_fault (misaligned_fault),
        .fetch_count      (fetch_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then check after the edge.
    task automatic tick(input logic rst, input logic st, input logic rv, input logic [63:0] tgt);
        cap_t c;
        bit   cap;
        cap = 1'b0;
        reset = rst;
        stall = st;
        redirect_valid = rv;
        redirect_target = tgt;
        if (rst) begin
            m_state = 0; m_pc = 64'h0; m_valid = 1'b0; m_fault = 1'b0; m_cnt = 32'h0;
        end else begin
            case (m_state)
                0: m_state = 1;
                1: begin
                    if (rv && tgt[1:0] == 2'b00) begin
                        m_pc = tgt; m_valid = 1'b0;
                    end else if (rv) begin
                        m_state = 2; m_fault = 1'b1; m_valid = 1'b0;
                    end else if (st) begin
                        // hold everything
                    end else if (m_pc >= 64'd149) begin
                        m_state = 2; m_valid = 1'b0;
                    end else begin
                        c.pc = m_pc;
                        c.inst = memword(m_pc);
                        sb.push_back(c);
                        cap = 1'b1;
                        m_valid = 1'b1;
                        m_pc = m_pc + 64'd4;
                        m_cnt = m_cnt + 32'd1;
                    end
                end
                default: begin
                    if (rv && tgt[1:0] == 2'b00) begin
                        m_pc = tgt; m_fault = 1'b0; m_state = 1;
                    end else if (rv) begin
                        m_fault = 1'b1;
                    end
                end
            endcase
        end
        @(posedge clk);
        @(negedge clk);
        chk("inst_address", inst_address, m_pc);
        chk("if_valid", {63'h0, if_valid}, {63'h0, m_valid});
        chk("halted", {63'h0, halted}, {63'h0, (m_state == 2)});
        chk("misaligned_fault", {63'h0, misaligned_fault}, {63'h0, m_fault});
        chk("fetch_count", {32'h0, fetch_count}, {32'h0, m_cnt});
        if (cap) last_cap = sb.pop_front();
        if (m_valid) begin
            chk("sb_if_pc", if_pc, last_cap.pc);
            chk("sb_if_instruction", {32'h0, if_instruction}, {32'h0, last_cap.inst});
        end else begin
            chk("bubble_nop", {32'h0, if_instruction}, 64'h13);
        end
    endtask

    initial begin
        for (int i = 0; i < 38; i++) mem[i] = 32'hC0DE0000 | 32'(i);
        mem[0] = 32'h00000000;
        mem[1] = 32'hff810113;

        // Reset state
        tick(1'b1, 1'b0, 1'b0, 64'h0);
        tick(1'b1, 1'b0, 1'b0, 64'h0);
        chk("rst_if_pc", if_pc, 64'h0);

        // Free-run: BOOT, capture 0, capture 4
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        chk("plan_if_pc", if_pc, 64'h4);
        chk("plan_if_inst", {32'h0, if_instruction}, 64'hff810113);
        chk("plan_count", {32'h0, fetch_count}, 64'd2);

        // Reach pc=16, stall three cycles, release
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'b0, 64'h0);
            chk("stall_addr", inst_address, 64'd16);
            chk("stall_if_pc", if_pc, 64'd12);
        end
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        chk("unstall_if_pc", if_pc, 64'd16);

        // Redirect wins over stall
        tick(1'b0, 1'b1, 1'b1, 64'h3C);
        chk("redir_addr", inst_address, 64'h3C);
        chk("redir_bubble", {63'h0, if_valid}, 64'h0);
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        chk("redir_if_pc", if_pc, 64'h3C);

        // Run to end of memory
        for (int k = 0; k < 60 && !(m_state == 1 && m_pc == 64'd152); k++)
            tick(1'b0, 1'b0, 1'b0, 64'h0);
        chk("end_if_pc", if_pc, 64'd148);
        chk("end_valid", {63'h0, if_valid}, 64'h1);
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        chk("end_halted", {63'h0, halted}, 64'h1);
        chk("end_addr", inst_address, 64'd152);
        tick(1'b0, 1'b1, 1'b0, 64'h0);
        tick(1'b0, 1'b0, 1'b0, 64'h0);

        // Restart from halt
        tick(1'b0, 1'b0, 1'b1, 64'h0);
        chk("restart_halted", {63'h0, halted}, 64'h0);
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        tick(1'b0, 1'b0, 1'b0, 64'h0);

        // Misaligned redirect, then aligned recovery
        tick(1'b0, 1'b0, 1'b1, 64'h42);
        chk("mis_fault", {63'h0, misaligned_fault}, 64'h1);
        chk("mis_addr", inst_address, 64'h8);
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        tick(1'b0, 1'b0, 1'b1, 64'h40);
        chk("recover_fault", {63'h0, misaligned_fault}, 64'h0);
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        chk("recover_if_pc", if_pc, 64'h40);

        // Reset during stall, then reset colliding with redirect
        tick(1'b0, 1'b1, 1'b0, 64'h0);
        tick(1'b1, 1'b1, 1'b0, 64'h0);
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        tick(1'b1, 1'b0, 1'b1, 64'h80);
        chk("rst_redir_addr", inst_address, 64'h0);
        chk("rst_redir_count", {32'h0, fetch_count}, 64'h0);
        // Redirect during BOOT is ignored
        tick(1'b0, 1'b0, 1'b1, 64'h80);
        chk("boot_ignore_addr", inst_address, 64'h0);
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        tick(1'b0, 1'b0, 1'b0, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
